// File: rtl/fifo_rr_merge_if.sv
// Bundle of signals between the round-robin merge and its FIFOs.
// The upstream side has N registered SRL FIFOs (EMPTY_N/DEQ/D_OUT).
// The downstream side has one SRL FIFO (FULL_N/ENQ/D_IN).
// The master modport is the merge block. The slave modport is its environment.
// Build option FIFO_RR_MERGE_MSGLIM_EN adds the sticky LIMIT_ERR flag.
interface fifo_rr_merge_if #(
   parameter int nsrc  = 4,
   parameter int width = 32
);
   logic [nsrc-1:0]       SRC_EN;
   logic [nsrc-1:0]       SRC_EMPTY_N;
   logic [nsrc*width-1:0] SRC_D;
   logic [nsrc-1:0]       SRC_DEQ;
   logic                  DST_FULL_N;
   logic                  DST_ENQ;
   logic [width-1:0]      DST_D;
   logic [2:0]            GRANT;
   logic                  BUSY;
`ifdef FIFO_RR_MERGE_MSGLIM_EN
   logic                  LIMIT_ERR;

   modport master (
      input  SRC_EN, SRC_EMPTY_N, SRC_D, DST_FULL_N,
      output SRC_DEQ, DST_ENQ, DST_D, GRANT, BUSY, LIMIT_ERR
   );

   modport slave (
      output SRC_EN, SRC_EMPTY_N, SRC_D, DST_FULL_N,
      input  SRC_DEQ, DST_ENQ, DST_D, GRANT, BUSY, LIMIT_ERR
   );
`else
   modport master (
      input  SRC_EN, SRC_EMPTY_N, SRC_D, DST_FULL_N,
      output SRC_DEQ, DST_ENQ, DST_D, GRANT, BUSY
   );

   modport slave (
      output SRC_EN, SRC_EMPTY_N, SRC_D, DST_FULL_N,
      input  SRC_DEQ, DST_ENQ, DST_D, GRANT, BUSY
   );
`endif
endinterface

// File: rtl/fifo_rr_merge.sv
// Round-robin merge of nsrc upstream FIFOs into one downstream FIFO.
// A grant is held until the end-of-message beat (data bit width-1).
// Messages from different sources therefore never interleave.
// Each message costs one arbitration bubble cycle in IDLE.
// Build option FIFO_RR_MERGE_MSGLIM_EN adds a per-message beat limit (maxbeats).
// When a message reaches that limit without EOP, the sticky LIMIT_ERR sets and
// the lock is dropped.
module fifo_rr_merge #(
   parameter int nsrc  = 4,
   parameter int width = 32
`ifdef FIFO_RR_MERGE_MSGLIM_EN
   ,
   parameter int maxbeats = 256
`endif
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            CLR,
   fifo_rr_merge_if.master bus
);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t           state_q;
   logic [2:0]       gnt_q;
   logic [2:0]       ptr_q;
   logic [2:0]       ptr_d;

   logic [nsrc-1:0]  req;
   logic             hi_vld, lo_vld, pick_vld;
   logic [2:0]       hi_idx, lo_idx, pick_idx;
   logic             sel_empty_n;
   logic [width-1:0] sel_d;
   logic             run;
   logic             xfer;
   logic             eop;

`ifdef FIFO_RR_MERGE_MSGLIM_EN
   localparam int cw = $clog2(maxbeats + 1);
   logic [cw-1:0]    beats_q;
   logic             lim_q;
   logic             last_beat;

   assign last_beat     = (beats_q == cw'(maxbeats - 1));
   assign bus.LIMIT_ERR = lim_q;
`endif

   assign req = bus.SRC_EN & bus.SRC_EMPTY_N;
   // Reset and clear both block any transfer in the cycle they are applied.
   assign run = RST_N & ~CLR;

   // Rotating-priority pick: the lowest requester at or above ptr_q, otherwise the lowest overall.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
      hi_vld = 1'b0;
      hi_idx = 3'd0;
      lo_vld = 1'b0;
      lo_idx = 3'd0;
      for (int k = nsrc - 1; k >= 0; k--) begin
         if (req[k]) begin
            lo_vld = 1'b1;
            lo_idx = 3'(k);
            if (3'(k) >= ptr_q) begin
               hi_vld = 1'b1;
               hi_idx = 3'(k);
            end
         end
      end
      pick_vld = lo_vld;
      pick_idx = hi_vld ? hi_idx : lo_idx;
   end

   assign ptr_d = (pick_idx == 3'(nsrc - 1)) ? 3'd0 : pick_idx + 3'd1;

   // Select the granted source's status and data.
   always_comb begin
      sel_empty_n = 1'b0;
      sel_d       = '0;
      for (int k = 0; k < nsrc; k++) begin
         if (gnt_q == 3'(k)) begin
            sel_empty_n = bus.SRC_EMPTY_N[k];
            sel_d       = bus.SRC_D[k*width +: width];
         end
      end
   end

   assign xfer = (state_q == LOCK) & sel_empty_n & bus.DST_FULL_N & run;
   assign eop  = sel_d[width-1];

   // Route the dequeue strobe to the granted source only.
   always_comb begin
      bus.SRC_DEQ = '0;
      for (int k = 0; k < nsrc; k++) begin
         if (gnt_q == 3'(k)) bus.SRC_DEQ[k] = xfer;
      end
   end

   assign bus.DST_ENQ = xfer;
   assign bus.DST_D   = (state_q == LOCK) ? sel_d : '0;
   assign bus.GRANT   = gnt_q;
   assign bus.BUSY    = (state_q == LOCK);

   // Arbitration FSM: grant in IDLE, then hold the lock until EOP (or until the beat limit, if enabled).
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, so it is sampled like any other input.
      if (!run) begin
         state_q <= IDLE;
         gnt_q   <= 3'd0;
         ptr_q   <= 3'd0;
`ifdef FIFO_RR_MERGE_MSGLIM_EN
         beats_q <= '0;
         lim_q   <= 1'b0;
`endif
      end else if (state_q == IDLE) begin
         if (pick_vld) begin
            gnt_q   <= pick_idx;
            ptr_q   <= ptr_d;
            state_q <= LOCK;
`ifdef FIFO_RR_MERGE_MSGLIM_EN
            beats_q <= '0;
`endif
         end
      end else begin
         if (xfer) begin
            if (eop) begin
               state_q <= IDLE;
               gnt_q   <= 3'd0;
            end
`ifdef FIFO_RR_MERGE_MSGLIM_EN
            else if (last_beat) begin
               lim_q   <= 1'b1;
               state_q <= IDLE;
               gnt_q   <= 3'd0;
            end else begin
               beats_q <= beats_q + 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Self-checking bench for fifo_rr_merge.
// Upstream FIFOs are modelled as queues. A message-level reference model tracks
// the current owner and the round-robin pointer, and predicts every output in
// every cycle.
`timescale 1ns/1ps
module tb_fifo_rr_merge;

   localparam int NSRC = 4;
   localparam int W    = 32;
   localparam int VW   = 1 + 1 + 3 + 1 + NSRC + W;
   localparam int P_ENQ  = W + NSRC;
   localparam int P_GNT  = W + NSRC + 1;
   localparam int P_BUSY = W + NSRC + 4;
   localparam int P_LIM  = W + NSRC + 5;
`ifdef FIFO_RR_MERGE_MSGLIM_EN
   localparam bit MSGLIM = 1'b1;
   localparam int MAXB   = 4;
`else
   localparam bit MSGLIM = 1'b0;
   localparam int MAXB   = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic clr;

   fifo_rr_merge_if #(.nsrc(NSRC), .width(W)) bus ();

`ifdef FIFO_RR_MERGE_MSGLIM_EN
   fifo_rr_merge #(.nsrc(NSRC), .width(W), .maxbeats(MAXB)) dut (
      .CLK(clk), .RST_N(rst_n), .CLR(clr), .bus(bus));
`else
   fifo_rr_merge #(.nsrc(NSRC), .width(W)) dut (
      .CLK(clk), .RST_N(rst_n), .CLR(clr), .bus(bus));
`endif

   always #5 clk = ~clk;

   // stimulus state
   logic [W-1:0]    src_q [NSRC][$];
   logic [W-1:0]    cur_d [NSRC];
   logic            rst_drv, clr_drv, full_drv;
   logic [NSRC-1:0] en_drv;

   // reference model: owner -1 means idle
   int m_owner, m_rr, m_beats;
   bit m_limit;

   int n_pass, n_checks, cyc;
   int           gnt_log[$];
   logic [W-1:0] dat_log[$];
   int           cyc_log[$];
   logic [VW-1:0] act, exp;

   task automatic step();
      logic            busy, xfer, lim_act;
      int              g;
      logic [NSRC-1:0] deq;
      logic [W-1:0]    dd, w;
      @(negedge clk);
      rst_n          = rst_drv;
      clr            = clr_drv;
      bus.SRC_EN     = en_drv;
      bus.DST_FULL_N = full_drv;
      for (int k = 0; k < NSRC; k++) begin
         cur_d[k] = (src_q[k].size() > 0) ? src_q[k][0] : W'($urandom);
         bus.SRC_EMPTY_N[k] = (src_q[k].size() > 0);
         bus.SRC_D[k*W +: W] = cur_d[k];
      end
      #1;
      busy = (m_owner >= 0);
      g    = busy ? m_owner : 0;
      xfer = busy && rst_drv && !clr_drv && full_drv && (src_q[g].size() > 0);
      deq  = xfer ? (NSRC'(1) << g) : '0;
      dd   = busy ? cur_d[g] : '0;
      exp  = {m_limit, busy, 3'(g), xfer, deq, dd};
`ifdef FIFO_RR_MERGE_MSGLIM_EN
      lim_act = bus.LIMIT_ERR;
`else
      lim_act = 1'b0;
`endif
      act = {lim_act, bus.BUSY, bus.GRANT, bus.DST_ENQ, bus.SRC_DEQ, bus.DST_D};
      if (bus.DST_ENQ === 1'b1) begin
         gnt_log.push_back(int'(bus.GRANT));
         dat_log.push_back(bus.DST_D);
         cyc_log.push_back(cyc);
      end
      cyc++;
      // advance the model to the state after the coming edge
      if (!(rst_drv && !clr_drv)) begin
         m_owner = -1; m_rr = 0; m_beats = 0; m_limit = 1'b0;
      end else if (m_owner < 0) begin
         for (int i = 0; i < NSRC; i++) begin
            int k = (m_rr + i) % NSRC;
            if (m_owner < 0 && en_drv[k] && src_q[k].size() > 0) begin
               m_owner = k; m_rr = (k + 1) % NSRC; m_beats = 0;
            end
         end
      end else if (xfer) begin
         w = src_q[g].pop_front();
         m_beats++;
         if (w[W-1]) m_owner = -1;
         else if (MSGLIM && m_beats == MAXB) begin
            m_limit = 1'b1; m_owner = -1;
         end
      end
   endtask

   task automatic do_reset();
      for (int k = 0; k < NSRC; k++) src_q[k].delete();
      rst_drv = 1'b0; clr_drv = 1'b0; full_drv = 1'b1; en_drv = '1;
      step();
      step();
      rst_drv = 1'b1;
      gnt_log.delete(); dat_log.delete(); cyc_log.delete();
   endtask

   task automatic test_reset();
      for (int k = 0; k < NSRC; k++) src_q[k].delete();
      rst_drv = 1'b0; clr_drv = 1'b0; full_drv = 1'b1; en_drv = '1;
      step();
      step();
      n_checks++;
      if (act !== exp) $display("FAIL reset_hold: got %h expected %h", act, exp);
      else n_pass++;
      rst_drv = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         n_checks++;
         if (act !== '0) $display("FAIL reset_idle: cycle %0d got %h expected 0", c, act);
         else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      int bad_gap = 0;
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < NSRC; k++) src_q[k].push_back({1'b1, 31'(r * 16 + k)});
      for (int c = 0; c < 40; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL rr_cycle: got %h expected %h", act, exp);
         else n_pass++;
      end
      n_checks++;
      if (gnt_log.size() != 12) $display("FAIL rr_count: got %0d enq expected 12", gnt_log.size());
      else n_pass++;
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (gnt_log[i] != i % NSRC) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, gnt_log[i], i % NSRC);
         else n_pass++;
      end
      for (int i = 1; i < cyc_log.size(); i++) if (cyc_log[i] - cyc_log[i-1] != 2) bad_gap++;
      n_checks++;
      if (bad_gap != 0) $display("FAIL rr_bubble: got %0d bad gaps expected 0", bad_gap);
      else n_pass++;
   endtask

   task automatic test_message_lock();
      logic [W-1:0] words [4];
      do_reset();
      for (int b = 0; b < 4; b++) begin
         words[b] = {(b == 3), 31'($urandom)};
         src_q[1].push_back(words[b]);
      end
      src_q[2].push_back({1'b1, 31'h222});
      for (int c = 0; c < 20; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL lock_cycle: got %h expected %h", act, exp);
         else n_pass++;
      end
      n_checks++;
      if (dat_log.size() != 5) $display("FAIL lock_count: got %0d expected 5", dat_log.size());
      else n_pass++;
      for (int b = 0; b < 4; b++) begin
         n_checks++;
         if (dat_log[b] !== words[b] || gnt_log[b] != 1)
            $display("FAIL lock_word[%0d]: got %h/src%0d expected %h/src1", b, dat_log[b], gnt_log[b], words[b]);
         else n_pass++;
      end
      n_checks++;
      if (cyc_log[3] - cyc_log[0] != 3) $display("FAIL lock_contig: got span %0d expected 3", cyc_log[3] - cyc_log[0]);
      else n_pass++;
      n_checks++;
      if (gnt_log[4] != 2) $display("FAIL lock_next: got src%0d expected src2", gnt_log[4]);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] words [6];
      bit reached = 0;
      do_reset();
      for (int b = 0; b < 6; b++) begin
         words[b] = {(b == 5), 31'($urandom)};
         src_q[0].push_back(words[b]);
      end
      for (int c = 0; c < 20 && !reached; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL bp_start: got %h expected %h", act, exp);
         else n_pass++;
         reached = (dat_log.size() == 2);
      end
      n_checks++;
      if (!reached) $display("FAIL bp_timeout: got %0d beats expected 2", dat_log.size());
      else n_pass++;
      full_drv = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         n_checks++;
         if (act !== exp || act[P_ENQ] !== 1'b0 || act[W +: NSRC] !== '0)
            $display("FAIL bp_stall: got %h expected %h", act, exp);
         else n_pass++;
      end
      full_drv = 1'b1;
      step();
      n_checks++;
      if (act[P_ENQ] !== 1'b1 || act[W-1:0] !== words[2])
         $display("FAIL bp_resume: got enq=%b d=%h expected enq=1 d=%h", act[P_ENQ], act[W-1:0], words[2]);
      else n_pass++;
      for (int c = 0; c < 12; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL bp_drain: got %h expected %h", act, exp);
         else n_pass++;
      end
      n_checks++;
      if (dat_log.size() != 6) $display("FAIL bp_count: got %0d expected 6", dat_log.size());
      else n_pass++;
      for (int b = 0; b < 6; b++) begin
         n_checks++;
         if (dat_log[b] !== words[b]) $display("FAIL bp_word[%0d]: got %h expected %h", b, dat_log[b], words[b]);
         else n_pass++;
      end
   endtask

   task automatic test_enable_mask();
      int want [4] = '{0, 2, 0, 2};
      do_reset();
      en_drv = 4'b0101;
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NSRC; k++) src_q[k].push_back({1'b1, 31'(k)});
      for (int c = 0; c < 16; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL mask_cycle: got %h expected %h", act, exp);
         else n_pass++;
      end
      n_checks++;
      if (gnt_log.size() != 4) $display("FAIL mask_count: got %0d expected 4", gnt_log.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (gnt_log[i] != want[i]) $display("FAIL mask_order[%0d]: got %0d expected %0d", i, gnt_log[i], want[i]);
         else n_pass++;
      end
      en_drv = '1;
      for (int c = 0; c < 16; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL mask_drain: got %h expected %h", act, exp);
         else n_pass++;
      end
   endtask

   task automatic test_clr();
      bit reached = 0;
      do_reset();
      for (int b = 0; b < 5; b++) src_q[1].push_back({(b == 4), 31'(100 + b)});
      for (int c = 0; c < 20 && !reached; c++) begin
         step();
         reached = (dat_log.size() == 2);
      end
      n_checks++;
      if (!reached) $display("FAIL clr_timeout: got %0d beats expected 2", dat_log.size());
      else n_pass++;
      src_q[0].push_back({1'b1, 31'h0a});
      src_q[3].push_back({1'b1, 31'h3a});
      clr_drv = 1'b1;
      step();
      n_checks++;
      if (act !== exp || act[P_ENQ] !== 1'b0 || act[W +: NSRC] !== '0)
         $display("FAIL clr_cycle: got %h expected %h", act, exp);
      else n_pass++;
      clr_drv = 1'b0;
      step();
      n_checks++;
      if (act[P_BUSY] !== 1'b0 || act[P_GNT +: 3] !== 3'd0)
         $display("FAIL clr_idle: got busy=%b gnt=%0d expected busy=0 gnt=0", act[P_BUSY], act[P_GNT +: 3]);
      else n_pass++;
      step();
      n_checks++;
      if (act[P_BUSY] !== 1'b1 || act[P_GNT +: 3] !== 3'd0)
         $display("FAIL clr_ptr: got busy=%b gnt=%0d expected busy=1 gnt=0", act[P_BUSY], act[P_GNT +: 3]);
      else n_pass++;
      for (int c = 0; c < 20; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL clr_drain: got %h expected %h", act, exp);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int total = 0;
         for (int k = 0; k < NSRC; k++) total += src_q[k].size();
         if (total < 12 && $urandom_range(0, 2) == 0) begin
            int k   = $urandom_range(0, NSRC - 1);
            int len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) src_q[k].push_back({(b == len - 1), 31'($urandom)});
         end
         en_drv   = ($urandom_range(0, 7) == 0) ? NSRC'($urandom) : '1;
         full_drv = ($urandom_range(0, 3) != 0);
         clr_drv  = ($urandom_range(0, 499) == 0);
         step();
         n_checks++;
         if (act !== exp) $display("FAIL rand_cycle %0d: got %h expected %h", c, act, exp);
         else n_pass++;
      end
      clr_drv = 1'b0; en_drv = '1; full_drv = 1'b1;
      for (int c = 0; c < 100; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL rand_drain: got %h expected %h", act, exp);
         else n_pass++;
      end
   endtask

`ifdef FIFO_RR_MERGE_MSGLIM_EN
   task automatic test_msg_limit();
      do_reset();
      for (int b = 0; b < 6; b++) src_q[0].push_back({1'b0, 31'(b)});
      for (int c = 0; c < 20; c++) begin
         step();
         n_checks++;
         if (act !== exp) $display("FAIL lim_cycle: got %h expected %h", act, exp);
         else n_pass++;
      end
      n_checks++;
      if (dat_log.size() != 6 || cyc_log[3] - cyc_log[0] != 3 || cyc_log[4] - cyc_log[3] != 2)
         $display("FAIL lim_split: got %0d beats expected 4+bubble+2", dat_log.size());
      else n_pass++;
      n_checks++;
      if (act[P_LIM] !== 1'b1 || act[P_BUSY] !== 1'b1)
         $display("FAIL lim_flag: got lim=%b busy=%b expected lim=1 busy=1", act[P_LIM], act[P_BUSY]);
      else n_pass++;
      src_q[0].push_back({1'b1, 31'h7});
      for (int c = 0; c < 4; c++) step();
      n_checks++;
      if (act[P_LIM] !== 1'b1 || act[P_BUSY] !== 1'b0 || dat_log.size() != 7)
         $display("FAIL lim_sticky: got lim=%b busy=%b beats=%0d expected lim=1 busy=0 beats=7",
                  act[P_LIM], act[P_BUSY], dat_log.size());
      else n_pass++;
   endtask
`endif

   initial begin
      n_pass = 0; n_checks = 0; cyc = 0;
      m_owner = -1; m_rr = 0; m_beats = 0; m_limit = 1'b0;
      rst_n = 1'b0; clr = 1'b0;
      bus.SRC_EN = '0; bus.SRC_EMPTY_N = '0; bus.SRC_D = '0; bus.DST_FULL_N = 1'b1;
      test_reset();
      test_round_robin();
      test_message_lock();
      test_backpressure();
      test_enable_mask();
      test_clr();
`ifdef FIFO_RR_MERGE_MSGLIM_EN
      test_msg_limit();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_rr_merge.md
Name: fifo_rr_merge

Overview:
- Round-robin arbiter that shares one downstream SRL FIFO (FULL_N/ENQ/D_IN side) among N upstream registered SRL FIFOs (EMPTY_N/DEQ/D_OUT side).
- Grants one source at a time and holds the grant until that source's end-of-message beat, so messages are never interleaved.
- Sits at merge points, e.g. multiple DMA/worker streams feeding one egress FIFO.

Parameters:
- nsrc, 4, number of upstream sources (2..8).
- width, 32, data width per source in bits; bit [width-1] is the EOP flag.

Ports:
- CLK  input  1  clock.
- RST_N  input  1  reset, synchronous, active-low.
- CLR  input  1  synchronous clear; same effect as reset.
- SRC_EN  input  nsrc  per-source enable mask; disabled sources are not granted.
- SRC_EMPTY_N  input  nsrc  upstream FIFO not-empty flags.
- SRC_D  input  nsrc*width  upstream FIFO D_OUT buses; source k occupies [k*width +: width].
- SRC_DEQ  output  nsrc  one-hot dequeue strobes to the upstream FIFOs.
- DST_FULL_N  input  1  downstream FIFO not-full.
- DST_ENQ  output  1  downstream enqueue strobe.
- DST_D  output  width  data to downstream D_IN; the EOP bit passes through unchanged.
- GRANT  output  3  index of the currently granted source; 0 when idle.
- BUSY  output  1  high while a message is locked.

Behaviour:
- State machine with states IDLE and LOCK. Registers: state, gnt (3b), ptr (3b round-robin pointer).
- Reset / CLR: state=IDLE, gnt=0, ptr=0. Outputs: SRC_DEQ=0, DST_ENQ=0, GRANT=0, BUSY=0.
- CLR has priority over every other event in the same cycle.
- Request vector: req[k] = SRC_EN[k] & SRC_EMPTY_N[k].

IDLE:
- If req is nonzero, select the first k with req[k] set, searching ptr, ptr+1, … modulo nsrc.
- On the next edge: gnt<=k, ptr<=(k+1) mod nsrc, state<=LOCK.
- No transfer occurs in IDLE, so every message costs exactly one arbitration bubble cycle.
- If req is zero, remain in IDLE and keep ptr unchanged.

LOCK:
- xfer = SRC_EMPTY_N[gnt] & DST_FULL_N. This is combinational, with no added latency.
- SRC_DEQ[gnt] = DST_ENQ = xfer. All other SRC_DEQ bits are 0.
- DST_D = SRC_D[gnt] whenever state=LOCK, and 0 in IDLE.
- If xfer is high and SRC_D[gnt][width-1] (EOP) is high, return to IDLE on the next edge; that IDLE cycle may grant again.
- Otherwise remain in LOCK. Source-empty or destination-full stalls the message indefinitely with no timeout.
- SRC_EN[gnt] deasserting mid-message does not break the lock; the message completes.
- GRANT=gnt, BUSY=1 during LOCK.

Boundary conditions:
- ptr wraps from nsrc-1 to 0.
- A single-beat message (EOP on its first beat) gives LOCK for one cycle, then IDLE.
- All sources continuously requesting gives grant order 0,1,2,3,0,…
- Reset mid-message drops the lock immediately; no DEQ is issued in the reset cycle.
- DST_ENQ is never high while DST_FULL_N is low.
- SRC_DEQ is never high while the corresponding SRC_EMPTY_N is low.

Optional Feature:
- Macro: FIFO_RR_MERGE_MSGLIM_EN.
- With the macro defined:
  - Adds parameter maxbeats (default 256) and output LIMIT_ERR (1b, sticky, cleared only by reset/CLR).
  - A beat counter resets on entering LOCK and increments on each xfer.
  - If a transfer would be beat number maxbeats without EOP, it is still passed through unaltered; LIMIT_ERR sets and the state forces to IDLE.
- Without the macro: no counter, no LIMIT_ERR port, and messages are unbounded.

Test Plan:
- Reset then idle: RST_N=0 for 2 cycles, all sources empty -> GRANT=0, BUSY=0, DST_ENQ=0, SRC_DEQ=0000 for 10 cycles.
- Round-robin fairness: sources 0..3 each hold three 1-beat messages, DST_FULL_N=1 -> grant sequence 0,1,2,3,0,1,2,3,0,1,2,3; 12 DST_ENQ pulses, each separated by one bubble.
- Message lock: src1 has a 4-beat message (EOP on beat 4) while src2 requests -> DST_D carries all 4 src1 words contiguously, then src2 is granted.
- Backpressure: in LOCK, DST_FULL_N=0 for 5 cycles mid-message -> DST_ENQ=0 and SRC_DEQ=0 throughout; resumes on the first cycle DST_FULL_N=1 with no data lost or duplicated.
- Enable mask/CLR: SRC_EN=0101 with all sources requesting -> grants only 0,2,0,2. CLR pulsed mid-message -> next cycle state IDLE, ptr=0, no DEQ issued in the CLR cycle.
- Optional limit (macro on, maxbeats=4): src0 sends 6 beats with no EOP -> 4 beats transferred, LIMIT_ERR=1, then IDLE; the remaining beats are re-arbitrated as a new message.
